mkio_rt_sa_ctrl: RTL and testbench

Parametrised MKIO (GOST R 52070) remote-terminal message controller, successor to the single-subaddress receive-only device block. Decodes the command word, handles both receive (BC→RT) and transmit (RT→BC) transfers for NUM_SA subaddresses with per-subaddress 32-word buffers, builds and sends the status word, and supports broadcast and inter-word timeout. Sits between the MKIO word decoder/encoder and the host-side register interface.

---
 rtl/mkio_rt_sa_ctrl_if.sv | 23 ++
 rtl/mkio_rt_sa_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mkio_rt_sa_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mkio_rt_sa_ctrl_if.sv
// MKIO word-level link between the decoder/encoder and the RT controller.
// The master drives received words and tx_ack; the slave drives the transmit word.
`timescale 1ns/1ps
interface mkio_rt_sa_ctrl_if;
    logic        start;
    logic        rx_done;
    logic [15:0] rx_data;
    logic        p_error;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_ready;
    logic        tx_ack;

    modport master (
        output start, rx_done, rx_data, p_error, tx_ack,
        input  tx_data, tx_cd, tx_ready
    );

    modport slave (
        input  start, rx_done, rx_data, p_error, tx_ack,
        output tx_data, tx_cd, tx_ready
    );
endinterface

// File: rtl/mkio_rt_sa_ctrl.sv
// MKIO remote-terminal message controller with NUM_SA receive/transmit subaddresses.
// Define MKIO_RX_DOUBLE_BUF_EN to get per-subaddress double-banked receive buffers.
`timescale 1ns/1ps
module mkio_rt_sa_ctrl #(
    parameter logic [4:0]  ADDRESS    = 5'd1,
    parameter int          NUM_SA     = 4,
    parameter logic [15:0] RX_TIMEOUT = 16'd1000,
    localparam int         SAW        = $clog2(NUM_SA)
) (
    input  logic            clk,
    input  logic            reset,
    mkio_rt_sa_ctrl_if.slave bus,
    input  logic            wr_en,
    input  logic [SAW-1:0]  wr_sa,
    input  logic [4:0]      wr_addr,
    input  logic [15:0]     wr_data,
    input  logic [SAW-1:0]  rd_sa,
    input  logic [4:0]      rd_addr,
    output logic [15:0]     rd_data,
    output logic            busy,
    output logic            msg_done,
    output logic            msg_err,
    output logic [4:0]      msg_sa
);
    localparam int         DEPTH = 32 << SAW;
    localparam logic [4:0] NSA   = 5'(NUM_SA);

    typedef enum logic [3:0] {
        IDLE, CMD, RX_WAIT, RX_SAVE, SW_LOAD,
        SW_SEND, TX_LOAD, TX_SEND, DONE
    } state_t;

    state_t      state;
    logic [15:0] cmd;
    logic        cmd_perr;
    logic        err;
    logic [4:0]  cnt;
    logic [15:0] tmo;
    logic [15:0] rx_word;
    logic        rx_perr;
    logic [15:0] tx_q;

    // The latched command word is the single source of T/R, SA and N.
    logic           tr;
    logic           bcast;
    logic           addr_hit;
    logic           start_hit;
    logic           sa_ok;
    logic [4:0]     n_last;
    logic [SAW-1:0] sa_i;
    logic           rx_we;

    assign tr        = cmd[10];
    assign bcast     = (cmd[15:11] == 5'd31);
    assign addr_hit  = (cmd[15:11] == ADDRESS) || bcast;
    assign start_hit = (bus.rx_data[15:11] == ADDRESS) ||
                       (bus.rx_data[15:11] == 5'd31);
    assign sa_ok     = (cmd[9:5] < NSA);
    assign n_last    = cmd[4:0] - 5'd1;
    assign sa_i      = cmd[SAW+4:5];
    assign rx_we     = (state == RX_SAVE) && sa_ok;

    logic [15:0] tx_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            tx_mem[{wr_sa, wr_addr}] <= wr_data;
    end

`ifdef MKIO_RX_DOUBLE_BUF_EN
    logic [(1<<SAW)-1:0] bank;
    logic [15:0]         rx_mem [2*DEPTH];
    logic [SAW+5:0]      widx;
    logic [SAW+5:0]      ridx;
    assign widx = {~bank[sa_i], sa_i, cnt};
    assign ridx = {bank[rd_sa], rd_sa, rd_addr};
`else
    logic [15:0]         rx_mem [DEPTH];
    logic [SAW+4:0]      widx;
    logic [SAW+4:0]      ridx;
    assign widx = {sa_i, cnt};
    assign ridx = {rd_sa, rd_addr};
`endif

    always_ff @(posedge clk) begin
        if (rx_we)
            rx_mem[widx] <= rx_word;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= 16'd0;
        else
            rd_data <= rx_mem[ridx];
    end

    task automatic finish(input logic e);
        state    <= DONE;
        msg_done <= 1'b1;
        msg_err  <= e;
        msg_sa   <= cmd[9:5];
`ifdef MKIO_RX_DOUBLE_BUF_EN
        if (!e && !tr && sa_ok)
            bank[sa_i] <= ~bank[sa_i];
`endif
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cmd          <= 16'd0;
            cmd_perr     <= 1'b0;
            err          <= 1'b0;
            cnt          <= 5'd0;
            tmo          <= 16'd0;
            rx_word      <= 16'd0;
            rx_perr      <= 1'b0;
            tx_q         <= 16'd0;
            bus.tx_data  <= 16'd0;
            bus.tx_cd    <= 1'b0;
            bus.tx_ready <= 1'b0;
            busy         <= 1'b0;
            msg_done     <= 1'b0;
            msg_err      <= 1'b0;
            msg_sa       <= 5'd0;
`ifdef MKIO_RX_DOUBLE_BUF_EN
            bank         <= '0;
`endif
        end else if (bus.start) begin
            // A new command always wins, silently dropping any message in flight.
            state        <= CMD;
            cmd          <= bus.rx_data;
            cmd_perr     <= bus.p_error;
            busy         <= start_hit;
            err          <= 1'b0;
            cnt          <= 5'd0;
            tmo          <= 16'd0;
            bus.tx_data  <= 16'd0;
            bus.tx_cd    <= 1'b0;
            bus.tx_ready <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            msg_done <= 1'b0;
            unique case (state)
                IDLE: ;
                CMD: begin
                    if (!addr_hit)
                        state <= IDLE;
                    else if (tr && bcast)
                        finish(1'b1);
                    else begin
                        err   <= cmd_perr || !sa_ok;
                        state <= tr ? SW_LOAD : RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    if (bus.rx_done) begin
                        rx_word <= bus.rx_data;
                        rx_perr <= bus.p_error;
                        tmo     <= 16'd0;
                        state   <= RX_SAVE;
                    end else if (tmo == RX_TIMEOUT)
                        finish(1'b1);
                    else
                        tmo <= tmo + 16'd1;
                end
                RX_SAVE: begin
                    if (cnt == n_last) begin
                        if (bcast)
                            finish(err || rx_perr);
                        else begin
                            err   <= err || rx_perr;
                            state <= SW_LOAD;
                        end
                    end else begin
                        err   <= err || rx_perr;
                        cnt   <= cnt + 5'd1;
                        tmo   <= 16'd0;
                        state <= RX_WAIT;
                    end
                end
                SW_LOAD: begin
                    bus.tx_data  <= {ADDRESS, err, 10'd0};
                    bus.tx_cd    <= 1'b1;
                    bus.tx_ready <= 1'b1;
                    state        <= SW_SEND;
                end
                SW_SEND: begin
                    if (bus.tx_ack) begin
                        bus.tx_ready <= 1'b0;
                        cnt          <= 5'd0;
                        if (tr && !err)
                            state <= TX_LOAD;
                        else
                            finish(err);
                    end
                end
                TX_LOAD: begin
                    tx_q  <= tx_mem[{sa_i, cnt}];
                    state <= TX_SEND;
                end
                TX_SEND: begin
                    if (!bus.tx_ready) begin
                        bus.tx_data  <= tx_q;
                        bus.tx_cd    <= 1'b0;
                        bus.tx_ready <= 1'b1;
                    end else if (bus.tx_ack) begin
                        bus.tx_ready <= 1'b0;
                        if (cnt == n_last)
                            finish(err);
                        else begin
                            cnt   <= cnt + 5'd1;
                            state <= TX_LOAD;
                        end
                    end
                end
                DONE: begin
                    busy        <= 1'b0;
                    bus.tx_data <= 16'd0;
                    bus.tx_cd   <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mkio_rt_sa_ctrl.sv
// Directed self-checking bench for mkio_rt_sa_ctrl (ADDRESS=1, NUM_SA=4).
// Expected values are hand-computed command/status words and buffer contents.
`timescale 1ns/1ps
module tb_mkio_rt_sa_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_sa;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_sa;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        msg_done;
    logic        msg_err;
    logic [4:0]  msg_sa;

    int n_chk  = 0;
    int n_fail = 0;

    mkio_rt_sa_ctrl_if bus ();

    mkio_rt_sa_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .wr_en    (wr_en),
        .wr_sa    (wr_sa),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_sa    (rd_sa),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .msg_done (msg_done),
        .msg_err  (msg_err),
        .msg_sa   (msg_sa)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic pe);
        bus.start   = 1'b1;
        bus.rx_data = w;
        bus.p_error = pe;
        tick();
        bus.start   = 1'b0;
        bus.p_error = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic pe);
        bus.rx_done = 1'b1;
        bus.rx_data = w;
        bus.p_error = pe;
        tick();
        bus.rx_done = 1'b0;
        bus.p_error = 1'b0;
    endtask

    task automatic ack();
        bus.tx_ack = 1'b1;
        tick();
        bus.tx_ack = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        logic found;
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (bus.tx_ready) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, found, 1'b1);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sa,
                          input logic [4:0] a, input logic [15:0] exp);
        rd_sa   = sa;
        rd_addr = a;
        tick();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic found;
        logic saw_rdy;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 16'd0;
        bus.p_error = 1'b0;
        bus.tx_ack  = 1'b0;
        wr_en = 1'b0; wr_sa = 2'd0; wr_addr = 5'd0; wr_data = 16'd0;
        rd_sa = 2'd0; rd_addr = 5'd0;
        idle(2);
        chk("rst_tx_data", bus.tx_data, 16'h0000);
        chk("rst_tx_cd", bus.tx_cd, 1'b0);
        chk("rst_tx_ready", bus.tx_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_msg_done", msg_done, 1'b0);
        chk("rst_msg_err", msg_err, 1'b0);
        chk("rst_msg_sa", msg_sa, 5'd0);
        chk("rst_rd_data", rd_data, 16'h0000);
        reset = 1'b0;
        idle(1);

        // Receive N=3 into SA1
        send_cmd(16'h0823, 1'b0);
        chk("rx1_busy", busy, 1'b1);
        idle(2);
        send_word(16'h1111, 1'b0); idle(2);
        send_word(16'h2222, 1'b0); idle(2);
        send_word(16'h3333, 1'b0);
        tick();
        chk("rx1_rdy_t2", bus.tx_ready, 1'b0);
        tick();
        chk("rx1_rdy_t3", bus.tx_ready, 1'b1);
        chk("rx1_sw", bus.tx_data, 16'h0800);
        chk("rx1_cd", bus.tx_cd, 1'b1);
        ack();
        chk("rx1_done", msg_done, 1'b1);
        chk("rx1_err", msg_err, 1'b0);
        chk("rx1_sa", msg_sa, 5'd1);
        chk("rx1_rdy_off", bus.tx_ready, 1'b0);
        tick();
        chk("rx1_done_pulse", msg_done, 1'b0);
        chk("rx1_busy_off", busy, 1'b0);
        rd_chk("rx1_rd0", 2'd1, 5'd0, 16'h1111);
        rd_chk("rx1_rd1", 2'd1, 5'd1, 16'h2222);
        rd_chk("rx1_rd2", 2'd1, 5'd2, 16'h3333);

        // Transmit 32 words from SA2
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_sa = 2'd2; wr_addr = 5'(i); wr_data = 16'(i);
            tick();
        end
        wr_en = 1'b0;
        send_cmd(16'h0C40, 1'b0);
        tick();
        chk("tx_sw_early", bus.tx_ready, 1'b0);
        tick();
        chk("tx_sw_rdy", bus.tx_ready, 1'b1);
        chk("tx_sw", bus.tx_data, 16'h0800);
        chk("tx_sw_cd", bus.tx_cd, 1'b1);
        ack();
        chk("tx_gap1", bus.tx_ready, 1'b0);
        tick();
        chk("tx_gap2", bus.tx_ready, 1'b0);
        tick();
        chk("tx_w0_rdy", bus.tx_ready, 1'b1);
        for (int i = 0; i < 32; i++) begin
            if (i > 0) wait_ready("tx_w_rdy");
            chk("tx_w_data", bus.tx_data, 16'(i));
            chk("tx_w_cd", bus.tx_cd, 1'b0);
            ack();
        end
        chk("tx_done", msg_done, 1'b1);
        chk("tx_err", msg_err, 1'b0);
        chk("tx_sa", msg_sa, 5'd2);
        idle(1);

        // Receive N=2 with parity error on the second word
        send_cmd(16'h0822, 1'b0);
        idle(2);
        send_word(16'hAAAA, 1'b0); idle(2);
        send_word(16'hBBBB, 1'b1);
        wait_ready("pe_rdy");
        chk("pe_sw", bus.tx_data, 16'h0C00);
        ack();
        chk("pe_done", msg_done, 1'b1);
        chk("pe_err", msg_err, 1'b1);
        idle(1);
`ifdef MKIO_RX_DOUBLE_BUF_EN
        rd_chk("pe_rd0", 2'd1, 5'd0, 16'h1111);
        rd_chk("pe_rd1", 2'd1, 5'd1, 16'h2222);
`else
        rd_chk("pe_rd0", 2'd1, 5'd0, 16'hAAAA);
        rd_chk("pe_rd1", 2'd1, 5'd1, 16'hBBBB);
`endif

        // Illegal subaddress 5
        send_cmd(16'h08A1, 1'b0);
        idle(2);
        send_word(16'h1234, 1'b0);
        wait_ready("ill_rdy");
        chk("ill_sw", bus.tx_data, 16'h0C00);
        ack();
        chk("ill_done", msg_done, 1'b1);
        chk("ill_err", msg_err, 1'b1);
        chk("ill_sa", msg_sa, 5'd5);
        idle(1);

        // Timeout: N=4 to SA3, only two words arrive
        send_cmd(16'h0864, 1'b0);
        idle(2);
        send_word(16'hCCCC, 1'b0); idle(2);
        send_word(16'hDDDD, 1'b0);
        found = 1'b0;
        saw_rdy = 1'b0;
        for (int j = 0; j < 1200; j++) begin
            if (bus.tx_ready) saw_rdy = 1'b1;
            if (msg_done) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("tmo_done", found, 1'b1);
        chk("tmo_no_sw", saw_rdy, 1'b0);
        chk("tmo_err", msg_err, 1'b1);
        chk("tmo_sa", msg_sa, 5'd3);
        idle(1);

        // Broadcast receive N=1 to SA1
        send_cmd(16'hF821, 1'b0);
        idle(2);
        send_word(16'h5A5A, 1'b0);
        tick();
        chk("bc_done", msg_done, 1'b1);
        chk("bc_err", msg_err, 1'b0);
        chk("bc_no_sw", bus.tx_ready, 1'b0);
        idle(1);
        rd_chk("bc_rd0", 2'd1, 5'd0, 16'h5A5A);

        // Command to another RT is ignored
        send_cmd(16'h2821, 1'b0);
        chk("oth_busy", busy, 1'b0);
        saw_rdy = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (busy || msg_done || bus.tx_ready) saw_rdy = 1'b1;
            tick();
        end
        chk("oth_quiet", saw_rdy, 1'b0);

        // Abort with a new start mid-message
        send_cmd(16'h0823, 1'b0);
        idle(2);
        send_word(16'h7777, 1'b0); idle(2);
        send_cmd(16'h0821, 1'b0);
        chk("ab_busy", busy, 1'b1);
        chk("ab_no_done", msg_done, 1'b0);
        idle(2);
        send_word(16'h4444, 1'b0);
        tick();
        chk("ab_rdy_t2", bus.tx_ready, 1'b0);
        tick();
        chk("ab_rdy_t3", bus.tx_ready, 1'b1);
        chk("ab_sw", bus.tx_data, 16'h0800);
        ack();
        chk("ab_done", msg_done, 1'b1);
        chk("ab_err", msg_err, 1'b0);
        idle(1);
        rd_chk("ab_rd0", 2'd1, 5'd0, 16'h4444);

        // Reset in the middle of a transmit
        send_cmd(16'h0C40, 1'b0);
        idle(2);
        chk("mr_rdy", bus.tx_ready, 1'b1);
        reset = 1'b1;
        tick();
        chk("mr_tx_ready", bus.tx_ready, 1'b0);
        chk("mr_tx_data", bus.tx_data, 16'h0000);
        chk("mr_tx_cd", bus.tx_cd, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_msg_done", msg_done, 1'b0);
        chk("mr_msg_sa", msg_sa, 5'd0);
        chk("mr_rd_data", rd_data, 16'h0000);
        reset = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
